// File: rtl/board_io_pkg.sv
// Shared board I/O constants for the debounced switch/button inputs.
package board_io_pkg;

  localparam int BOARD_NUM_SW       = 8;
  localparam int BOARD_NUM_BTN      = 5;
  localparam int BOARD_NUM_CH       = BOARD_NUM_SW + BOARD_NUM_BTN;
  localparam int DEBOUNCE_CNT_WIDTH = 20;
  localparam logic [DEBOUNCE_CNT_WIDTH-1:0] DEBOUNCE_DEFAULT_LIMIT = 20'd1_000_000; // 10 ms at 100 MHz

  localparam int BOARD_SW_BASE  = 0;
  localparam int BOARD_BTN_BASE = BOARD_NUM_SW;

  // Init window spans SYNC_STAGES+1 cycles; one extra state marks it finished.
  function automatic int init_cnt_width(input int sync_stages);
    return $clog2(sync_stages + 2);
  endfunction

endpackage

// File: rtl/board_input_debounce_if.sv
// Pin-side and register-side signal bundle of the input debounce block.
interface board_input_debounce_if
  import board_io_pkg::*;
#(
  parameter int NUM_CH    = BOARD_NUM_CH,
  parameter int CNT_WIDTH = DEBOUNCE_CNT_WIDTH
);
  logic [NUM_CH-1:0]    in_raw;
  logic [CNT_WIDTH-1:0] debounce_limit;
  logic [NUM_CH-1:0]    rise_mask;
  logic [NUM_CH-1:0]    fall_mask;
  logic [NUM_CH-1:0]    irq_clear;
  logic [NUM_CH-1:0]    in_stable;
  logic [NUM_CH-1:0]    rise_pulse;
  logic [NUM_CH-1:0]    fall_pulse;
  logic [NUM_CH-1:0]    irq_status;
  logic                 irq;

  modport master (
    output in_raw, debounce_limit, rise_mask, fall_mask, irq_clear,
    input  in_stable, rise_pulse, fall_pulse, irq_status, irq
  );

  modport slave (
    input  in_raw, debounce_limit, rise_mask, fall_mask, irq_clear,
    output in_stable, rise_pulse, fall_pulse, irq_status, irq
  );
endinterface

// File: rtl/board_debounce_ch.sv
// One input channel: synchroniser, stability counter, debounced level and edge pulses.
module board_debounce_ch #(
  parameter int CNT_WIDTH   = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 in_raw,
  input  logic [CNT_WIDTH-1:0] debounce_limit,
  input  logic                 init_load,
  output logic                 in_stable,
  output logic                 rise_pulse,
  output logic                 fall_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   sync_lvl;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q     <= '0;
      cnt        <= '0;
      in_stable  <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], in_raw};
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (init_load) begin
        // boot capture: adopt the pin level silently
        in_stable <= sync_lvl;
        cnt       <= '0;
      end else if (sync_lvl == in_stable) begin
        cnt <= '0;
      end else if (cnt >= debounce_limit) begin
        in_stable  <= sync_lvl;
        cnt        <= '0;
        rise_pulse <= sync_lvl;
        fall_pulse <= ~sync_lvl;
      end else begin
        cnt <= cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/board_input_debounce.sv
// Debounce, edge detect and sticky maskable interrupt status for board inputs.
// Optional boot capture window enabled by BOARD_DEBOUNCE_INIT_CAPTURE_EN.
module board_input_debounce
  import board_io_pkg::*;
#(
  parameter int NUM_CH      = BOARD_NUM_CH,
  parameter int CNT_WIDTH   = DEBOUNCE_CNT_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input logic                   clk,
  input logic                   resetn,
  board_input_debounce_if.slave bus
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES must be in 2..4");
  end

  logic              init_load;
  logic [NUM_CH-1:0] stable;
  logic [NUM_CH-1:0] rise;
  logic [NUM_CH-1:0] fall;
  logic [NUM_CH-1:0] status_q;
  logic [NUM_CH-1:0] set_evt;
  logic              irq_q;

`ifdef BOARD_DEBOUNCE_INIT_CAPTURE_EN
  localparam int INIT_W = init_cnt_width(SYNC_STAGES);
  localparam logic [INIT_W-1:0] INIT_LEN = INIT_W'(SYNC_STAGES + 1);

  logic [INIT_W-1:0] init_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      init_cnt <= '0;
    else if (init_cnt != INIT_LEN)
      init_cnt <= init_cnt + INIT_W'(1);
  end

  assign init_load = (init_cnt != INIT_LEN);
`else
  assign init_load = 1'b0;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    board_debounce_ch #(
      .CNT_WIDTH   (CNT_WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_ch (
      .clk            (clk),
      .resetn         (resetn),
      .in_raw         (bus.in_raw[g]),
      .debounce_limit (bus.debounce_limit),
      .init_load      (init_load),
      .in_stable      (stable[g]),
      .rise_pulse     (rise[g]),
      .fall_pulse     (fall[g])
    );
  end

  assign set_evt = (rise & bus.rise_mask) | (fall & bus.fall_mask);

  // set has priority over a coincident clear
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      status_q <= (status_q & ~bus.irq_clear) | set_evt;
      irq_q    <= |status_q;
    end
  end

  assign bus.in_stable  = stable;
  assign bus.rise_pulse = rise;
  assign bus.fall_pulse = fall;
  assign bus.irq_status = status_q;
  assign bus.irq        = irq_q;

endmodule

// File: tb/tb_board_input_debounce.sv
// Directed, table-driven bench for board_input_debounce (13 channels, 2 sync stages).
module tb_board_input_debounce;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  int   errs = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  board_input_debounce_if #(.NUM_CH(13), .CNT_WIDTH(20)) bus ();

  board_input_debounce #(.NUM_CH(13), .CNT_WIDTH(20), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  typedef struct {
    logic [12:0] in_raw;
    logic [19:0] lim;
    logic [12:0] rm;
    logic [12:0] fm;
    logic [12:0] clr;
    int          cyc;
    logic [12:0] e_stable;
    logic [12:0] e_status;
    logic        e_irq;
  } vec_t;

  vec_t tbl[12];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  initial begin
    int first;
    int npulse;
    logic [12:0] pw;

    // in_raw, lim, rise_mask, fall_mask, clr, cycles, exp stable, exp status, exp irq
    tbl[0]  = '{13'h000, 20'd2, 13'h001, 13'h000, 13'h000, 10, 13'h000, 13'h000, 1'b0};
    tbl[1]  = '{13'h001, 20'd2, 13'h001, 13'h000, 13'h000, 10, 13'h001, 13'h001, 1'b1};
    tbl[2]  = '{13'h000, 20'd2, 13'h001, 13'h000, 13'h000, 10, 13'h000, 13'h001, 1'b1};
    tbl[3]  = '{13'h000, 20'd2, 13'h001, 13'h000, 13'h001,  1, 13'h000, 13'h000, 1'b1};
    tbl[4]  = '{13'h000, 20'd2, 13'h001, 13'h000, 13'h000,  1, 13'h000, 13'h000, 1'b0};
    tbl[5]  = '{13'h104, 20'd2, 13'h004, 13'h100, 13'h000, 10, 13'h104, 13'h004, 1'b1};
    tbl[6]  = '{13'h004, 20'd2, 13'h004, 13'h100, 13'h000, 10, 13'h004, 13'h104, 1'b1};
    tbl[7]  = '{13'h004, 20'd2, 13'h004, 13'h100, 13'h1FFF, 1, 13'h004, 13'h000, 1'b1};
    tbl[8]  = '{13'h004, 20'd2, 13'h004, 13'h100, 13'h000,  1, 13'h004, 13'h000, 1'b0};
    tbl[9]  = '{13'h000, 20'd2, 13'h000, 13'h000, 13'h000, 10, 13'h000, 13'h000, 1'b0};
    tbl[10] = '{13'h008, 20'd5, 13'h1FFF, 13'h1FFF, 13'h000, 4, 13'h000, 13'h000, 1'b0};
    tbl[11] = '{13'h000, 20'd5, 13'h1FFF, 13'h1FFF, 13'h000, 10, 13'h000, 13'h000, 1'b0};

    bus.in_raw = '0; bus.debounce_limit = 20'd5;
    bus.rise_mask = '0; bus.fall_mask = '0; bus.irq_clear = '0;

    // reset state
    #20;
    chk("rst_stable", 32'(bus.in_stable), 32'h0);
    chk("rst_rise",   32'(bus.rise_pulse), 32'h0);
    chk("rst_fall",   32'(bus.fall_pulse), 32'h0);
    chk("rst_status", 32'(bus.irq_status), 32'h0);
    chk("rst_irq",    32'(bus.irq), 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    tick(5);

    // clean step on ch0, limit 5 -> accepted 8 cycles later
    bus.in_raw = 13'h001;
    first = 0; npulse = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (bus.in_stable[0] && first == 0) first = k;
      if (bus.rise_pulse[0]) npulse++;
    end
    chk("step_latency", 32'(first), 32'd8);
    chk("step_npulse",  32'(npulse), 32'd1);

    for (int i = 0; i < 12; i++) begin
      bus.in_raw = tbl[i].in_raw; bus.debounce_limit = tbl[i].lim;
      bus.rise_mask = tbl[i].rm; bus.fall_mask = tbl[i].fm; bus.irq_clear = tbl[i].clr;
      tick(tbl[i].cyc);
      chk($sformatf("vec%0d_stable", i), 32'(bus.in_stable), 32'(tbl[i].e_stable));
      chk($sformatf("vec%0d_status", i), 32'(bus.irq_status), 32'(tbl[i].e_status));
      chk($sformatf("vec%0d_irq", i),    32'(bus.irq), 32'(tbl[i].e_irq));
    end
    bus.irq_clear = '0;

    // status set and clear on the same cycle: set wins
    bus.debounce_limit = 20'd2; bus.rise_mask = 13'h004; bus.fall_mask = '0;
    bus.in_raw = 13'h004;
    tick(5);
    chk("sc_pulse",  32'(bus.rise_pulse), 32'h004);
    chk("sc_before", 32'(bus.irq_status), 32'h000);
    bus.irq_clear = 13'h004;
    tick(1);
    bus.irq_clear = '0;
    chk("sc_status", 32'(bus.irq_status), 32'h004);

    // limit lowered below current count: commit on the next cycle
    bus.rise_mask = '0; bus.debounce_limit = 20'd100;
    bus.in_raw = 13'h006;
    tick(52);
    chk("lower_wait", 32'(bus.in_stable), 32'h004);
    bus.debounce_limit = 20'd10;
    tick(1);
    chk("lower_stable", 32'(bus.in_stable), 32'h006);
    chk("lower_pulse",  32'(bus.rise_pulse), 32'h002);
    tick(1);
    chk("lower_pulse_end", 32'(bus.rise_pulse), 32'h000);

    // limit raised mid-count: count continues toward new limit
    bus.debounce_limit = 20'd5;
    bus.in_raw = 13'h004;
    tick(5);
    bus.debounce_limit = 20'd20;
    tick(17);
    chk("raise_wait", 32'(bus.in_stable), 32'h006);
    tick(1);
    chk("raise_stable", 32'(bus.in_stable), 32'h004);
    chk("raise_fall",   32'(bus.fall_pulse), 32'h002);

    // all inputs high through a mid-debounce reset
    bus.in_raw = 13'h1FFF; bus.debounce_limit = 20'd4;
    bus.rise_mask = 13'h1FFF; bus.fall_mask = '0; bus.irq_clear = '0;
    tick(2);
    resetn = 1'b0;
    #2;
    chk("midrst_stable", 32'(bus.in_stable), 32'h0);
    chk("midrst_status", 32'(bus.irq_status), 32'h0);
    @(posedge clk); #1 resetn = 1'b1;
    first = 0; npulse = 0; pw = '0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (bus.rise_pulse != 0) begin
        npulse++;
        if (first == 0) begin first = k; pw = bus.rise_pulse; end
      end
`ifdef BOARD_DEBOUNCE_INIT_CAPTURE_EN
      if (k == 2) chk("init_k2_stable", 32'(bus.in_stable), 32'h0);
      if (k == 3) chk("init_k3_stable", 32'(bus.in_stable), 32'h1FFF);
`endif
    end
`ifdef BOARD_DEBOUNCE_INIT_CAPTURE_EN
    chk("init_npulse", 32'(npulse), 32'd0);
    chk("init_status", 32'(bus.irq_status), 32'h0);
    chk("init_irq",    32'(bus.irq), 32'h0);
`else
    chk("boot_first",  32'(first), 32'd7);
    chk("boot_word",   32'(pw), 32'h1FFF);
    chk("boot_npulse", 32'(npulse), 32'd1);
    chk("boot_status", 32'(bus.irq_status), 32'h1FFF);
    chk("boot_irq",    32'(bus.irq), 32'h1);
`endif
    chk("boot_stable", 32'(bus.in_stable), 32'h1FFF);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/board_input_debounce.md
Name: board_input_debounce

Overview:
- Parametrised conditioning block for the board's mechanical inputs: switches, buttons and the timer capture pin.
- Inputs are synchronised into the fabric clock and debounced per channel with a run-time programmable hold time.
- The block detects rising and falling edges and keeps a sticky, maskable interrupt status per channel.
- It sits between the top-level input pins and the PS-facing register/GPIO logic; it replaces direct wiring of board_sw/board_btn into the block design.

Parameters:
- NUM_CH, 13, number of input channels (default covers 8 switches plus 5 buttons).
- CNT_WIDTH, 20, width of the per-channel debounce counter and of debounce_limit.
- SYNC_STAGES, 2, flip-flop stages in the input synchroniser; legal range 2..4.

Ports:
- clk  input  1  fabric clock; all logic is in this single domain.
- resetn  input  1  asynchronous active-low reset.
- in_raw  input  NUM_CH  raw asynchronous pin levels.
- debounce_limit  input  CNT_WIDTH  stable cycles required before a level change is accepted; quasi-static.
- rise_mask  input  NUM_CH  per-channel enable for setting status on a rising edge.
- fall_mask  input  NUM_CH  per-channel enable for setting status on a falling edge.
- irq_clear  input  NUM_CH  one-cycle write-1-to-clear pulses for irq_status.
- in_stable  output  NUM_CH  debounced levels.
- rise_pulse  output  NUM_CH  one-cycle pulse when in_stable goes 0->1.
- fall_pulse  output  NUM_CH  one-cycle pulse when in_stable goes 1->0.
- irq_status  output  NUM_CH  sticky per-channel event flags.
- irq  output  1  registered OR of irq_status.

Behaviour:
- Reset values: all outputs, counters and synchroniser flops are 0.
- Synchroniser: in_raw passes through SYNC_STAGES flops to produce sync[i].
- Per-channel counter cnt[i]:
  - If sync[i] == in_stable[i]: cnt[i] <= 0.
  - Else if cnt[i] >= debounce_limit: in_stable[i] <= sync[i], cnt[i] <= 0, and the matching rise/fall pulse is asserted for exactly one cycle, coincident with the in_stable update.
  - Else: cnt[i] <= cnt[i] + 1.
  - The counter never wraps, because the >= compare fires before overflow.
- Latency: a clean step on in_raw appears on in_stable SYNC_STAGES + debounce_limit + 1 clk cycles later.
- debounce_limit = 0: accepted one cycle after sync changes.
- A glitch shorter than debounce_limit + 1 sync cycles produces no change and no pulse.
- debounce_limit lowered mid-count below cnt[i]: the >= compare commits on the next cycle.
- debounce_limit raised mid-count: counting continues toward the new limit.
- irq_status[i]:
  - Set when (rise_pulse & rise_mask) or (fall_pulse & fall_mask).
  - Cleared when irq_clear[i] is high.
  - Set and clear in the same cycle: set wins.
- irq is registered, so it is 1 cycle behind irq_status.
- Mask changes affect future edges only; existing status bits are not cleared by masking.
- resetn asserted mid-debounce: everything returns to 0 immediately.
  - Without the optional feature, a channel held high through reset produces a rise_pulse after SYNC_STAGES + debounce_limit + 1 cycles.
- No handshake; all channels are independent. A compile-time check fails if SYNC_STAGES < 2.

Optional Feature:
- Macro: BOARD_DEBOUNCE_INIT_CAPTURE_EN.
- Defined:
  - For the first SYNC_STAGES + 1 cycles after resetn deasserts, in_stable is loaded directly from sync and counters are held at 0.
  - No rise_pulse, fall_pulse or status set occurs in that window, so switch positions at boot raise no interrupts.
  - A 2-bit init counter tracks the window.
- Not defined: no init window; the post-reset edge behaviour is as above.

Decomposition:
- Package board_io_pkg:
  - constants BOARD_NUM_SW = 8, BOARD_NUM_BTN = 5, DEBOUNCE_CNT_WIDTH = 20, DEBOUNCE_DEFAULT_LIMIT = 20'd1_000_000 (10 ms at 100 MHz);
  - localparam for channel index bases (SW at 0, BTN at 8).
- Sub-module board_debounce_ch: one channel holding the synchroniser, counter, stable flop and edge pulses; instantiated NUM_CH times by a generate loop.
- The top level keeps the status/mask/irq logic and the init window.

Test Plan:
1. debounce_limit = 5, ch0 steps 0->1 and holds → in_stable[0] = 1 and a single rise_pulse[0] exactly 8 cycles after the step (SYNC_STAGES = 2); cnt returns to 0.
2. debounce_limit = 5, ch3 glitches high for 4 cycles → in_stable[3] stays 0, no pulses, irq_status = 0.
3. rise_mask = 0x001, fall_mask = 0x000, ch0 toggles 1 then 0 → irq_status[0] sets on the rise only; irq follows 1 cycle later; irq_clear[0] pulse clears status and irq drops the next cycle.
4. Status-set and irq_clear on the same cycle for ch2 → irq_status[2] remains 1.
5. debounce_limit = 100, at cnt = 50 change limit to 10 → commit on the next cycle with one pulse.
6. All 13 inputs high through reset; release resetn:
   - feature off: 13 rise_pulses at cycle SYNC_STAGES + limit + 1;
   - feature on: in_stable = 0x1FFF after 3 cycles, zero pulses, irq_status = 0.
